// File: rtl/mmio_pkg.sv
// Shared constants and types for the MMIO responder: page offsets, decode select, blank segment code.
package mmio_pkg;

  localparam logic [31:0] OFF_DISP   = 32'h00;
  localparam logic [31:0] OFF_SW     = 32'h04;
  localparam logic [31:0] OFF_TCOUNT = 32'h08;
  localparam logic [31:0] OFF_TCMP   = 32'h0C;
  localparam logic [31:0] OFF_STATUS = 32'h10;

  typedef enum logic [2:0] {
    SEL_RAM,
    SEL_DISP,
    SEL_SW,
    SEL_TCOUNT,
    SEL_TCMP,
    SEL_STATUS,
    SEL_NONE
  } addr_sel_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/mmio_responder_if.sv
// Load/store data bus between the MIPS core (master) and the MMIO responder (slave).
interface mmio_responder_if;
  logic        memwrite;
  logic [31:0] dataadr;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output memwrite,
    output dataadr,
    output writedata,
    input  readdata
  );

  modport slave (
    input  memwrite,
    input  dataadr,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/hex7seg.sv
// Hex nibble to active-low 7-segment decoder, segment order {g,f,e,d,c,b,a}.
module hex7seg
  import mmio_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/mmio_responder.sv
// Data-side responder: word RAM, 7-seg display register and MMIO page (switches, optional timer).
// Define MMIO_TIMER_EN to build the TCOUNT/TCMP/STATUS timer registers.
module mmio_responder
  import mmio_pkg::*;
#(
  parameter int unsigned RAM_WORDS = 64,
  parameter logic [31:0] IO_BASE   = 32'h0000_FF00
) (
  input  logic             clk,
  input  logic             reset,
  mmio_responder_if.slave  bus,
  input  logic [4:0]       SW,
  output logic [6:0]       gled,
  output logic [6:0]       gled2,
  output logic [6:0]       gled3,
  output logic [6:0]       gled4
);

  localparam int AW = $clog2(RAM_WORDS);

  addr_sel_t   sel;
  logic [31:0] word_addr;
  logic [15:0] disp_q;
  logic [4:0]  sw_meta_q, sw_sync_q;
  logic [31:0] tcount_rd, tcmp_rd, status_rd;
  logic [31:0] ram [RAM_WORDS];
  logic        unused_addr_lsbs;

  assign unused_addr_lsbs = ^bus.dataadr[1:0];
  assign word_addr        = {bus.dataadr[31:2], 2'b00};

  // MMIO page is checked first; RAM needs every bit above its index to be zero.
  always_comb begin
    sel = SEL_NONE;
    if (word_addr == IO_BASE + OFF_DISP) begin
      sel = SEL_DISP;
    end else if (word_addr == IO_BASE + OFF_SW) begin
      sel = SEL_SW;
`ifdef MMIO_TIMER_EN
    end else if (word_addr == IO_BASE + OFF_TCOUNT) begin
      sel = SEL_TCOUNT;
    end else if (word_addr == IO_BASE + OFF_TCMP) begin
      sel = SEL_TCMP;
    end else if (word_addr == IO_BASE + OFF_STATUS) begin
      sel = SEL_STATUS;
`endif
    end else if (bus.dataadr[31:AW+2] == '0) begin
      sel = SEL_RAM;
    end
  end

  always_ff @(posedge clk) begin
    if (bus.memwrite && sel == SEL_RAM) begin
      ram[bus.dataadr[AW+1:2]] <= bus.writedata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      disp_q    <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      sw_meta_q <= SW;
      sw_sync_q <= sw_meta_q;
      if (bus.memwrite && sel == SEL_DISP) begin
        disp_q <= bus.writedata[15:0];
      end
    end
  end

`ifdef MMIO_TIMER_EN
  logic [31:0] tcount_q, tcmp_q;
  logic        status_q;

  // A match sets the sticky flag even if a write-1 clear lands on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tcount_q <= '0;
      tcmp_q   <= 32'hFFFF_FFFF;
      status_q <= 1'b0;
    end else begin
      if (bus.memwrite && sel == SEL_TCOUNT) begin
        tcount_q <= bus.writedata;
      end else begin
        tcount_q <= tcount_q + 32'd1;
      end
      if (bus.memwrite && sel == SEL_TCMP) begin
        tcmp_q <= bus.writedata;
      end
      if (tcount_q == tcmp_q) begin
        status_q <= 1'b1;
      end else if (bus.memwrite && sel == SEL_STATUS && bus.writedata[0]) begin
        status_q <= 1'b0;
      end
    end
  end

  assign tcount_rd = tcount_q;
  assign tcmp_rd   = tcmp_q;
  assign status_rd = {31'b0, status_q};
`else
  assign tcount_rd = '0;
  assign tcmp_rd   = '0;
  assign status_rd = '0;
`endif

  always_comb begin
    bus.readdata = '0;
    unique case (sel)
      SEL_RAM:    bus.readdata = ram[bus.dataadr[AW+1:2]];
      SEL_DISP:   bus.readdata = {16'b0, disp_q};
      SEL_SW:     bus.readdata = {27'b0, sw_sync_q};
      SEL_TCOUNT: bus.readdata = tcount_rd;
      SEL_TCMP:   bus.readdata = tcmp_rd;
      SEL_STATUS: bus.readdata = status_rd;
      default:    bus.readdata = '0;
    endcase
  end

  hex7seg u_dig0 (.nibble(disp_q[3:0]),   .seg(gled));
  hex7seg u_dig1 (.nibble(disp_q[7:4]),   .seg(gled2));
  hex7seg u_dig2 (.nibble(disp_q[11:8]),  .seg(gled3));
  hex7seg u_dig3 (.nibble(disp_q[15:12]), .seg(gled4));

endmodule

// File: tb/tb_mmio_responder.sv
// Directed self-checking bench for mmio_responder; timer checks follow MMIO_TIMER_EN.
module tb_mmio_responder;

  localparam logic [31:0] IO = 32'h0000_FF00;

  logic       clk;
  logic       reset;
  logic [4:0] SW;
  logic [6:0] gled, gled2, gled3, gled4;
  int         n_checks;
  int         n_fail;

  mmio_responder_if bus_if ();

  mmio_responder #(
    .RAM_WORDS(64),
    .IO_BASE  (IO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if),
    .SW   (SW),
    .gled (gled),
    .gled2(gled2),
    .gled3(gled3),
    .gled4(gled4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    bus_if.memwrite  = 1'b1;
    bus_if.dataadr   = addr;
    bus_if.writedata = data;
    tick();
    bus_if.memwrite  = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    bus_if.dataadr = addr;
    #1;
    data = bus_if.readdata;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    reset = 1'b0;
    tick();
    bus_write(IO + 32'h00, 32'h0000_FFFF);  // ignored while held in reset
    bus_read(IO + 32'h00, rd);
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++; $display("FAIL reset_disp: got %h expected %h", rd, 32'h0);
    end
    n_checks++;
    if ({gled, gled2, gled3, gled4} !== {4{7'b1000000}}) begin
      n_fail++;
      $display("FAIL reset_gled: got %b %b %b %b expected 1000000 x4", gled, gled2, gled3, gled4);
    end
    bus_read(IO + 32'h10, rd);
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++; $display("FAIL reset_status: got %h expected %h", rd, 32'h0);
    end
    bus_read(IO + 32'h04, rd);
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++; $display("FAIL reset_sw: got %h expected %h", rd, 32'h0);
    end
`ifdef MMIO_TIMER_EN
    bus_read(IO + 32'h0C, rd);
    n_checks++;
    if (rd !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL reset_tcmp: got %h expected %h", rd, 32'hFFFF_FFFF);
    end
    bus_read(IO + 32'h08, rd);
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++; $display("FAIL reset_tcount_hold: got %h expected %h", rd, 32'h0);
    end
    reset = 1'b1;
    tick();
    bus_read(IO + 32'h08, rd);
    n_checks++;
    if (rd !== 32'h1) begin
      n_fail++; $display("FAIL reset_release_count: got %h expected %h", rd, 32'h1);
    end
`else
    reset = 1'b1;
    tick();
`endif
  endtask

  task automatic test_ram();
    logic [31:0] rd;
    bus_write(32'h04, 32'hDEAD_BEEF);
    bus_read(32'h04, rd);
    n_checks++;
    if (rd !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL ram_rw: got %h expected %h", rd, 32'hDEAD_BEEF);
    end
    bus_write(32'hFC, 32'h0BAD_F00D);
    bus_read(32'hFC, rd);
    n_checks++;
    if (rd !== 32'h0BAD_F00D) begin
      n_fail++; $display("FAIL ram_top_word: got %h expected %h", rd, 32'h0BAD_F00D);
    end
    bus_read(32'h100, rd);
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++; $display("FAIL unmapped_read: got %h expected %h", rd, 32'h0);
    end
    bus_write(32'h104, 32'h5555_5555);  // would alias word 1 if upper bits were ignored
    bus_read(32'h04, rd);
    n_checks++;
    if (rd !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL ram_no_alias: got %h expected %h", rd, 32'hDEAD_BEEF);
    end
    bus_if.memwrite  = 1'b1;
    bus_if.dataadr   = 32'h04;
    bus_if.writedata = 32'h1234_5678;
    #1;
    n_checks++;
    if (bus_if.readdata !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL ram_rdw_old: got %h expected %h", bus_if.readdata, 32'hDEAD_BEEF);
    end
    tick();
    bus_if.memwrite = 1'b0;
    bus_read(32'h04, rd);
    n_checks++;
    if (rd !== 32'h1234_5678) begin
      n_fail++; $display("FAIL ram_rdw_new: got %h expected %h", rd, 32'h1234_5678);
    end
  endtask

  task automatic test_disp();
    logic [31:0] rd;
    bus_write(IO + 32'h00, 32'hABCD_1A3F);
    bus_read(IO + 32'h00, rd);
    n_checks++;
    if (rd !== 32'h0000_1A3F) begin
      n_fail++; $display("FAIL disp_readback: got %h expected %h", rd, 32'h0000_1A3F);
    end
    n_checks++;
    if (gled !== 7'b0001110) begin
      n_fail++; $display("FAIL gled_F: got %b expected %b", gled, 7'b0001110);
    end
    n_checks++;
    if (gled2 !== 7'b0110000) begin
      n_fail++; $display("FAIL gled2_3: got %b expected %b", gled2, 7'b0110000);
    end
    n_checks++;
    if (gled3 !== 7'b0001000) begin
      n_fail++; $display("FAIL gled3_A: got %b expected %b", gled3, 7'b0001000);
    end
    n_checks++;
    if (gled4 !== 7'b1111001) begin
      n_fail++; $display("FAIL gled4_1: got %b expected %b", gled4, 7'b1111001);
    end
  endtask

  task automatic test_switch();
    logic [31:0] rd;
    SW = 5'b10101;
    bus_write(IO + 32'h04, 32'h0000_001F);  // SWREG is read-only
    bus_read(IO + 32'h04, rd);
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++; $display("FAIL sw_one_edge: got %h expected %h", rd, 32'h0);
    end
    tick();
    bus_read(IO + 32'h04, rd);
    n_checks++;
    if (rd !== 32'h15) begin
      n_fail++; $display("FAIL sw_two_edges: got %h expected %h", rd, 32'h15);
    end
  endtask

`ifdef MMIO_TIMER_EN
  task automatic test_timer();
    logic [31:0] rd;
    bus_write(IO + 32'h0C, 32'd10);
    bus_write(IO + 32'h08, 32'd5);
    for (int i = 0; i < 5; i++) tick();
    bus_read(IO + 32'h10, rd);
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++; $display("FAIL timer_before_match: got %h expected %h", rd, 32'h0);
    end
    tick();
    bus_read(IO + 32'h10, rd);
    n_checks++;
    if (rd !== 32'h1) begin
      n_fail++; $display("FAIL timer_match_set: got %h expected %h", rd, 32'h1);
    end
    bus_write(IO + 32'h10, 32'h0);
    bus_read(IO + 32'h10, rd);
    n_checks++;
    if (rd !== 32'h1) begin
      n_fail++; $display("FAIL status_write0: got %h expected %h", rd, 32'h1);
    end
    bus_write(IO + 32'h10, 32'h1);
    bus_read(IO + 32'h10, rd);
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++; $display("FAIL status_clear: got %h expected %h", rd, 32'h0);
    end
    bus_write(IO + 32'h08, 32'd100);
    bus_write(IO + 32'h0C, 32'd30);
    bus_write(IO + 32'h08, 32'd25);
    for (int i = 0; i < 5; i++) tick();
    bus_write(IO + 32'h10, 32'h1);  // clear lands on the edge the match sets
    bus_read(IO + 32'h10, rd);
    n_checks++;
    if (rd !== 32'h1) begin
      n_fail++; $display("FAIL set_beats_clear: got %h expected %h", rd, 32'h1);
    end
    bus_write(IO + 32'h08, 32'hFFFF_FFFE);
    bus_read(IO + 32'h08, rd);
    n_checks++;
    if (rd !== 32'hFFFF_FFFE) begin
      n_fail++; $display("FAIL tcount_load: got %h expected %h", rd, 32'hFFFF_FFFE);
    end
    tick();
    bus_read(IO + 32'h08, rd);
    n_checks++;
    if (rd !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL tcount_max: got %h expected %h", rd, 32'hFFFF_FFFF);
    end
    tick();
    bus_read(IO + 32'h08, rd);
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++; $display("FAIL tcount_wrap: got %h expected %h", rd, 32'h0);
    end
  endtask
`else
  task automatic test_timer_absent();
    logic [31:0] rd;
    bus_write(IO + 32'h08, 32'h1111_1111);
    bus_write(IO + 32'h0C, 32'h2222_2222);
    bus_write(IO + 32'h10, 32'h1);
    tick();
    bus_read(IO + 32'h08, rd);
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++; $display("FAIL no_timer_tcount: got %h expected %h", rd, 32'h0);
    end
    bus_read(IO + 32'h0C, rd);
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++; $display("FAIL no_timer_tcmp: got %h expected %h", rd, 32'h0);
    end
    bus_read(IO + 32'h10, rd);
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++; $display("FAIL no_timer_status: got %h expected %h", rd, 32'h0);
    end
  endtask
`endif

  initial begin
    n_checks         = 0;
    n_fail           = 0;
    reset            = 1'b0;
    SW               = 5'b0;
    bus_if.memwrite  = 1'b0;
    bus_if.dataadr   = 32'h0;
    bus_if.writedata = 32'h0;
    #1;
    test_reset();
    test_ram();
    test_disp();
    test_switch();
`ifdef MMIO_TIMER_EN
    test_timer();
`else
    test_timer_absent();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
